// File: rtl/spi_ram_wrap.sv
// SPI master + two SPI slaves sharing one bus, backed by a dual-port RAM (slave 0 -> port A, slave 1 -> port B).
// A frame is 1 clk to accept, 64 clk to shift and 1 clk to close; start is a level request accepted only in IDLE.

module spi_ram_dpram #(
  parameter int DEPTH = 256,
  parameter int AW    = 8,
  parameter int W     = 8
) (
  input  logic          clk,
  input  logic          a_en,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [W-1:0]  a_din,
  output logic [W-1:0]  a_dout,
  input  logic          b_en,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [W-1:0]  b_din,
  output logic [W-1:0]  b_dout
);
  logic [W-1:0] mem [0:DEPTH-1];

  // Port A is written last, so it wins a same-address collision.
  always_ff @(posedge clk) begin
    if (b_en && b_we) mem[b_addr] <= b_din;
    if (a_en && a_we) mem[a_addr] <= a_din;
    if (a_en) a_dout <= mem[a_addr];
    if (b_en) b_dout <= mem[b_addr];
  end
endmodule

// Clk-synchronous SPI slave: detects SCLK edges, writes RAM on the last sample of a write frame,
// and serves read data on MISO for the second half of a read frame.
module spi_ram_slave #(
  parameter int cpol = 0,
  parameter int cpha = 0,
  parameter int W    = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         sclk,
  input  logic         cs_n,
  input  logic         rd,
  input  logic         mosi,
  input  logic [W-1:0] ram_dout,
  output logic         miso,
  output logic         ram_en,
  output logic         ram_we,
  output logic [W-1:0] ram_addr,
  output logic [W-1:0] ram_din
);
  localparam int   CW         = $clog2(2*W+1);
  localparam logic SCLK_IDLE  = (cpol != 0);
  localparam logic SAMPLE_LVL = (cpol != 0) ^ (cpha == 0);

  logic          sclk_d;
  logic [CW-1:0] cnt;
  logic [W-2:0]  sh;
  logic [W-1:0]  addr_q;
  logic [W-1:0]  tsh;
  logic [W-1:0]  tsrc;
  logic          rd_issue;
  logic          rd_load;
  logic          miso_q;
  logic          sclk_edge;
  logic          sample;
  logic          drive;
  logic          wr_now;

  assign sclk_edge = !cs_n && (sclk != sclk_d);
  assign sample    = sclk_edge && (sclk == SAMPLE_LVL);
  assign drive     = sclk_edge && (sclk != SAMPLE_LVL);
  assign wr_now    = sample && !rd && (cnt == CW'(2*W-1));
  assign tsrc      = rd_load ? ram_dout : tsh;

  always_ff @(posedge clk) begin
    sclk_d <= rst ? SCLK_IDLE : sclk;
    if (rst || cs_n) begin
      cnt      <= '0;
      sh       <= '0;
      addr_q   <= '0;
      tsh      <= '0;
      rd_issue <= 1'b0;
      rd_load  <= 1'b0;
      miso_q   <= 1'b0;
    end else begin
      rd_issue <= 1'b0;
      rd_load  <= rd_issue;
      if (rd_load) tsh <= ram_dout;
      if (sample) begin
        sh  <= {sh[W-3:0], mosi};
        cnt <= cnt + 1'b1;
        if (cnt == CW'(W-1)) begin
          addr_q   <= {sh, mosi};
          rd_issue <= rd;
        end
      end
      // Read data goes out on drive edges so it is stable at the master's sample edge.
      if (drive && rd && (cnt >= CW'(W)) && (cnt < CW'(2*W))) begin
        miso_q <= tsrc[W-1];
        tsh    <= {tsrc[W-2:0], 1'b0};
      end
    end
  end

  assign miso     = miso_q;
  assign ram_en   = rd_issue || wr_now;
  assign ram_we   = wr_now;
  assign ram_addr = addr_q;
  assign ram_din  = {sh, mosi};
endmodule

module spi_ram_wrap #(
  parameter int N         = 2,
  parameter int cpol      = 0,
  parameter int cpha      = 0,
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   startTx,
  input  logic                   startRx,
  input  logic                   which_slave_enabled,
  input  logic [2*ADDR_SIZE-1:0] spi_din,
  output logic                   spi_mosi,
  output logic                   spi_miso,
  output logic [2*ADDR_SIZE-1:0] spi_bits_sent,
  output logic [N-1:0]           spi_cs
);
  localparam int   W          = ADDR_SIZE;
  localparam int   FW         = 2*W;
  localparam int   FRAME_CLKS = 4*FW;
  localparam int   CW         = $clog2(FRAME_CLKS);
  localparam int   BW         = $clog2(FW);
  localparam int   AW         = $clog2(MEM_DEPTH);
  localparam logic SCLK_IDLE  = (cpol != 0);
  localparam logic CPHA_B     = (cpha != 0);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic [FW-1:0] frame;
  logic          sel;
  logic          rd;
  logic [W-1:0]  rx_sh;
  logic          sclk;
  logic          sample;
  logic [BW-1:0] bit_idx;
  logic [BW-1:0] mosi_idx;

  logic          s0_miso, s0_en, s0_we, s1_miso, s1_en, s1_we;
  logic [W-1:0]  s0_addr, s0_din, s1_addr, s1_din, a_dout, b_dout;

  function automatic logic [AW-1:0] wrap_addr(input logic [W-1:0] a);
    return AW'(32'(a) % MEM_DEPTH);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (startTx || startRx) state_nxt = SHIFT;
      SHIFT:   if (cnt == CW'(FRAME_CLKS-1)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt           <= '0;
      frame         <= '0;
      sel           <= 1'b0;
      rd            <= 1'b0;
      rx_sh         <= '0;
      spi_bits_sent <= '0;
    end else begin
      case (state)
        IDLE: if (startTx || startRx) begin
          frame <= spi_din;
          sel   <= which_slave_enabled;
          rd    <= !startTx;
          cnt   <= '0;
        end
        SHIFT: begin
          cnt <= cnt + 1'b1;
          if (sample) rx_sh <= {rx_sh[W-2:0], spi_miso};
        end
        DONE: spi_bits_sent <= rd ? {frame[FW-1:W], rx_sh} : frame;
        default: ;
      endcase
    end
  end

  // Each bit spans 4 clk: drive at phase 0, sample at phase 2, for either cpha.
  assign bit_idx  = cnt[CW-1:2];
  assign mosi_idx = BW'(FW-1) - bit_idx;
  assign sample   = (state == SHIFT) && (cnt[1:0] == 2'd2);
  assign sclk     = (state == SHIFT) ? (SCLK_IDLE ^ cnt[1] ^ CPHA_B) : SCLK_IDLE;
  assign spi_mosi = (state == SHIFT) ? frame[mosi_idx] : 1'b0;
  assign spi_cs   = (state == SHIFT) ? ~(N'(1) << sel) : '1;
  assign spi_miso = (!spi_cs[0] && s0_miso) || (!spi_cs[1] && s1_miso);

  spi_ram_slave #(.cpol(cpol), .cpha(cpha), .W(W)) slave0 (
    .clk(clk), .rst(rst), .sclk(sclk), .cs_n(spi_cs[0]), .rd(rd), .mosi(spi_mosi),
    .ram_dout(a_dout), .miso(s0_miso), .ram_en(s0_en), .ram_we(s0_we),
    .ram_addr(s0_addr), .ram_din(s0_din)
  );

  spi_ram_slave #(.cpol(cpol), .cpha(cpha), .W(W)) slave1 (
    .clk(clk), .rst(rst), .sclk(sclk), .cs_n(spi_cs[1]), .rd(rd), .mosi(spi_mosi),
    .ram_dout(b_dout), .miso(s1_miso), .ram_en(s1_en), .ram_we(s1_we),
    .ram_addr(s1_addr), .ram_din(s1_din)
  );

  spi_ram_dpram #(.DEPTH(MEM_DEPTH), .AW(AW), .W(W)) ram_inst (
    .clk(clk),
    .a_en(s0_en), .a_we(s0_we), .a_addr(wrap_addr(s0_addr)), .a_din(s0_din), .a_dout(a_dout),
    .b_en(s1_en), .b_we(s1_we), .b_addr(wrap_addr(s1_addr)), .b_din(s1_din), .b_dout(b_dout)
  );
endmodule

// File: tb/tb_spi_ram_wrap.sv
// Drives directed and random SPI write/read frames and compares the serial streams, chip selects,
// frame results and RAM contents against a byte-array model of the memory.
module tb_spi_ram_wrap;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        startTx = 1'b0;
  logic        startRx = 1'b0;
  logic        which_slave_enabled = 1'b0;
  logic [15:0] spi_din = '0;
  logic        spi_mosi;
  logic        spi_miso;
  logic [15:0] spi_bits_sent;
  logic [1:0]  spi_cs;

  int errors = 0;
  int checks = 0;
  logic [7:0] mem_m [256];
  bit         known [256];

  spi_ram_wrap dut (
    .clk(clk), .rst(rst), .startTx(startTx), .startRx(startRx),
    .which_slave_enabled(which_slave_enabled), .spi_din(spi_din),
    .spi_mosi(spi_mosi), .spi_miso(spi_miso), .spi_bits_sent(spi_bits_sent), .spi_cs(spi_cs)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One frame; abort_bit >= 0 pulses rst during that bit instead of completing.
  task automatic run_frame(input bit tx, input bit rx, input bit sel, input logic [15:0] din,
                           input int abort_bit);
    logic [15:0] mo = '0;
    logic [15:0] mi = '0;
    logic [15:0] exp_mi;
    logic [15:0] exp_sent;
    logic [7:0]  a = din[15:8];
    bit          is_rd = !tx;
    @(negedge clk);
    startTx = tx; startRx = rx; which_slave_enabled = sel; spi_din = din;
    @(negedge clk);
    startTx = 1'b0; startRx = 1'b0;
    check("cs_assert", 16'(spi_cs), sel ? 16'h0001 : 16'h0002);
    check("mosi_first", 16'(spi_mosi), 16'(din[15]));
    for (int k = 0; k < 64; k++) begin
      if (k > 0) @(negedge clk);
      if (k == 10) begin
        spi_din = 16'($urandom);
        which_slave_enabled = ~sel;
      end
      if (abort_bit >= 0 && k == abort_bit*4 + 1) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_cs", 16'(spi_cs), 16'h0003);
        check("abort_mosi", 16'(spi_mosi), 16'h0000);
        check("abort_miso", 16'(spi_miso), 16'h0000);
        check("abort_sent", spi_bits_sent, 16'h0000);
        repeat (2) @(negedge clk);
        check("abort_mem", 16'(dut.ram_inst.mem[a]), 16'(mem_m[a]));
        return;
      end
      if (k % 4 == 2) begin
        mo = {mo[14:0], spi_mosi};
        mi = {mi[14:0], spi_miso};
      end
    end
    @(negedge clk);
    check("cs_release", 16'(spi_cs), 16'h0003);
    @(negedge clk);
    if (is_rd) begin
      exp_sent = {a, mem_m[a]};
      exp_mi   = {8'h00, mem_m[a]};
    end else begin
      mem_m[a] = din[7:0];
      known[a] = 1'b1;
      exp_sent = din;
      exp_mi   = 16'h0000;
    end
    check("mosi_stream", mo, din);
    check("miso_stream", mi, exp_mi);
    check("bits_sent", spi_bits_sent, exp_sent);
    check("mem", 16'(dut.ram_inst.mem[a]), 16'(mem_m[a]));
  endtask

  initial begin
    for (int i = 0; i < 256; i++) known[i] = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_cs", 16'(spi_cs), 16'h0003);
    check("rst_mosi", 16'(spi_mosi), 16'h0000);
    check("rst_miso", 16'(spi_miso), 16'h0000);
    check("rst_sent", spi_bits_sent, 16'h0000);
    rst = 1'b0;

    run_frame(1, 0, 0, 16'hABCD, -1);
    run_frame(0, 1, 0, 16'hABBB, -1);
    run_frame(1, 0, 1, 16'h1234, -1);
    run_frame(0, 1, 1, 16'h12AB, -1);
    run_frame(1, 0, 0, 16'h5500, -1);
    run_frame(1, 0, 0, 16'h5566, 5);
    run_frame(0, 1, 1, 16'h5500, -1);
    run_frame(1, 1, 1, 16'h77EE, -1);
    run_frame(0, 1, 0, 16'h7700, -1);

    for (int n = 0; n < 16; n++) begin
      logic [7:0] a = 8'h20 + 8'($urandom_range(0, 3));
      bit         tx = !known[a] || ($urandom_range(0, 1) == 0);
      bit         sel = 1'($urandom_range(0, 1));
      logic [7:0] d = 8'($urandom);
      run_frame(tx, !tx || ($urandom_range(0, 1) == 0), sel, {a, d}, -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
